// File: rtl/sp_ram_burst_reader.sv
// Purpose : turns one (base, len) burst command into sp_ram word reads and streams the data out in order.
// Latency : first request one cycle after start; returned word is visible on rdata_o one cycle after its rvalid.
// Backpres: issue is credit-limited so outstanding reads plus buffered words never exceed FIFO_DEPTH.
//
// Ports: clk/rst_n (async active-low); start_i/base_addr_i/len_i command, busy_o/done_o status;
//        port_* sp_ram request/grant/rvalid master side (read-only, be_o all ones);
//        rdata_valid_o/rdata_o/rdata_ready_i downstream valid/ready stream.
// Optional: define SP_RAM_BURST_PERF_EN to add stall_cnt_o (saturating issue-stall cycle counter).
module sp_ram_burst_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    port_req_o,
    output logic [ADDR_WIDTH-1:0]   port_addr_o,
    output logic                    port_we_o,
    output logic [DATA_WIDTH-1:0]   port_wdata_o,
    output logic [DATA_WIDTH/8-1:0] be_o,
    input  logic                    port_gnt_i,
    input  logic                    port_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   port_rdata_i,
    output logic                    rdata_valid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic                    rdata_ready_i
`ifdef SP_RAM_BURST_PERF_EN
    ,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  done_q, done_d;

    logic credit_ok, issue_pend, grant, push, pop;

    // Credits: every granted read owns a FIFO slot until it is popped.
    assign credit_ok  = ({1'b0, cnt_q} + {1'b0, outst_q}) < DEPTH_W;
    assign issue_pend = (state_q == ST_ISSUE) && (remain_q != '0);
    assign grant      = port_req_o && port_gnt_i;
    // rvalid with nothing outstanding is stale (e.g. survived a reset) and is dropped.
    assign push       = port_rvalid_i && (outst_q != '0);
    assign pop        = (cnt_q != '0) && rdata_ready_i;

    assign port_req_o    = issue_pend && credit_ok;
    assign port_addr_o   = addr_q;
    assign port_we_o     = 1'b0;
    assign port_wdata_o  = '0;
    assign be_o          = '1;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign rdata_valid_o = (cnt_q != '0);
    assign rdata_o       = mem_q[rptr_q];

    always_comb begin
        outst_d = outst_q;
        if (grant && !push)
            outst_d = outst_q + CW'(1);
        else if (!grant && push)
            outst_d = outst_q - CW'(1);

        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push && pop)
            cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        addr_d   = base_addr_i;
                        remain_d = len_i;
                        state_d  = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (grant) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1))
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && (cnt_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            if (push) begin
                mem_q[wptr_q] <= port_rdata_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop)
                rptr_q <= rptr_q + PW'(1);
        end
    end

`ifdef SP_RAM_BURST_PERF_EN
    logic [15:0] stall_q;
    logic        stall_ev;

    assign stall_ev    = (port_req_o && !port_gnt_i) || (issue_pend && !credit_ok);
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if ((state_q == ST_IDLE) && start_i)
            stall_q <= '0;
        else if (stall_ev && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sp_ram_burst_reader.sv
// Scoreboarded bench for sp_ram_burst_reader: directed bursts, sp_ram responder model,
// negedge monitor comparing granted addresses and delivered words against expected queues.
module tb_sp_ram_burst_reader;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, port_req_o, port_we_o;
    logic [AW-1:0] port_addr_o;
    logic [DW-1:0] port_wdata_o;
    logic [DW/8-1:0] be_o;
    logic          port_gnt_i;
    logic          port_rvalid_i = 1'b0;
    logic [DW-1:0] port_rdata_i  = '0;
    logic          rdata_valid_o;
    logic [DW-1:0] rdata_o;
    logic          rdata_ready_i;
`ifdef SP_RAM_BURST_PERF_EN
    logic [15:0]   stall_cnt_o;
`endif

    sp_ram_burst_reader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .port_req_o(port_req_o), .port_addr_o(port_addr_o),
        .port_we_o(port_we_o), .port_wdata_o(port_wdata_o), .be_o(be_o), .port_gnt_i(port_gnt_i),
        .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i), .rdata_valid_o(rdata_valid_o),
        .rdata_o(rdata_o), .rdata_ready_i(rdata_ready_i)
`ifdef SP_RAM_BURST_PERF_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    int grant_cnt = 0, pop_cnt = 0, done_cnt = 0, max_infl = 0;
    int grant_cyc[$];
    int pop_cyc[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_dat_q[$];
    int            rsp_due[$];
    logic [DW-1:0] rsp_dat[$];

    // sp_ram memory contents as a function of address.
    function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
        return {8'hA5, a, ~a, 8'h3C};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // sp_ram responder: each grant returns its word lat cycles later; not cleared by DUT reset.
    always @(negedge clk) begin
        if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            port_rvalid_i = 1'b1;
            port_rdata_i  = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
        end else begin
            port_rvalid_i = 1'b0;
            port_rdata_i  = '0;
        end
        if (rst_n && port_req_o && port_gnt_i) begin
            rsp_due.push_back(cyc + lat);
            rsp_dat.push_back(mval(port_addr_o));
        end
    end

    // Monitor: compares every accepted request and every delivered word with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && port_req_o && port_gnt_i) begin
            grant_cnt++;
            grant_cyc.push_back(cyc);
            if (exp_addr_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_grant: addr %0d granted, none expected", port_addr_o);
            end else
                check("grant_addr", 64'(port_addr_o), 64'(exp_addr_q.pop_front()));
        end
        if (rst_n && rdata_valid_o && rdata_ready_i) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if (exp_dat_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_rdata: got %0h, none expected", rdata_o);
            end else
                check("rdata", 64'(rdata_o), 64'(exp_dat_q.pop_front()));
        end
        if (done_o) done_cnt++;
        if (grant_cnt - pop_cnt > max_infl) max_infl = grant_cnt - pop_cnt;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            exp_dat_q.push_back(mval(a));
            a = a + 8'd1;
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input logic [LW-1:0] n);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = base; len_i = n;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_o) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: done_o not seen within 200 cycles, expected a pulse", name);
        end
    endtask

    task automatic wait_grants(input int g0, input int n);
        for (int i = 0; i < 20 && (grant_cnt - g0) < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int d0, g0;
        rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        port_gnt_i = 1'b1; rdata_ready_i = 1'b1;
        #2;
        check("reset_outputs", 64'({busy_o, done_o, port_req_o, port_addr_o, rdata_valid_o, rdata_o}), 64'(0));
        check("tie_offs", 64'({port_we_o, port_wdata_o, be_o}), 64'({1'b0, 32'h0, 4'hF}));
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Basic burst: four back-to-back grants and pops.
        expect_burst(8'd128, 4);
        grant_cyc.delete(); pop_cyc.delete(); d0 = done_cnt;
        start_burst(8'd128, 9'd4);
        check("basic_busy", 64'(busy_o), 64'(1));
        wait_done("basic");
        idle(4);
        check("basic_grants", 64'(grant_cyc.size()), 64'(4));
        if (grant_cyc.size() == 4) check("basic_grant_span", 64'(grant_cyc[3] - grant_cyc[0]), 64'(3));
        if (pop_cyc.size() == 4) check("basic_pop_span", 64'(pop_cyc[3] - pop_cyc[0]), 64'(3));
        check("basic_done_pulses", 64'(done_cnt - d0), 64'(1));
        check("basic_idle", 64'({busy_o, port_req_o}), 64'(0));

        // Grant stall on the second request: address must hold at 141.
        expect_burst(8'd140, 3);
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(8'd140, 9'd3);
        wait_grants(g0, 1);
        port_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", 64'({port_req_o, port_addr_o}), 64'({1'b1, 8'd141}));
            @(posedge clk); #1;
        end
        port_gnt_i = 1'b1;
        wait_done("stall");
        idle(4);
        check("stall_grants", 64'(grant_cnt - g0), 64'(3));
        check("stall_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Credits: consumer stalled, only FIFO_DEPTH reads may be in flight.
        expect_burst(8'd64, 8);
        rdata_ready_i = 1'b0; max_infl = 0; d0 = done_cnt; g0 = grant_cnt;
        start_burst(8'd64, 9'd8);
        idle(12);
        check("credit_grants", 64'(grant_cnt - g0), 64'(4));
        check("credit_req_low", 64'(port_req_o), 64'(0));
        check("credit_head", 64'({rdata_valid_o, rdata_o}), 64'({1'b1, mval(8'd64)}));
        rdata_ready_i = 1'b1;
        wait_done("credit");
        idle(4);
        check("credit_max_inflight", 64'(max_infl), 64'(4));
        check("credit_total_grants", 64'(grant_cnt - g0), 64'(8));
        check("credit_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Address wrap, then a zero-length command.
        expect_burst(8'd254, 4);
        d0 = done_cnt;
        start_burst(8'd254, 9'd4);
        wait_done("wrap");
        idle(4);
        check("wrap_done_pulses", 64'(done_cnt - d0), 64'(1));
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(8'd50, 9'd0);
        check("zero_len_now", 64'({done_o, busy_o, port_req_o}), 64'({1'b1, 1'b0, 1'b0}));
        idle(4);
        check("zero_len_no_grant", 64'(grant_cnt - g0), 64'(0));
        check("zero_len_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Reset with two reads outstanding; their late rvalids must be dropped.
        expect_burst(8'd160, 4);
        lat = 3; g0 = grant_cnt;
        start_burst(8'd160, 9'd4);
        wait_grants(g0, 2);
        check("rst_outstanding", 64'(grant_cnt - g0), 64'(2));
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 64'({busy_o, done_o, port_req_o, port_addr_o, rdata_valid_o, rdata_o}), 64'(0));
        exp_addr_q.delete(); exp_dat_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        check("rst_stale_ignored", 64'({rdata_valid_o, busy_o}), 64'(0));
        lat = 1;
        expect_burst(8'd136, 2);
        d0 = done_cnt;
        start_burst(8'd136, 9'd2);
        wait_done("post_rst");
        idle(4);
        check("post_rst_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Start while busy is ignored.
        expect_burst(8'd32, 5);
        d0 = done_cnt; g0 = grant_cnt;
        start_burst(8'd32, 9'd5);
        start_i = 1'b1; base_addr_i = 8'd0; len_i = 9'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done("ignored_start");
        idle(5);
        check("ignored_start_grants", 64'(grant_cnt - g0), 64'(5));
        check("ignored_start_done_pulses", 64'(done_cnt - d0), 64'(1));
        check("ignored_start_idle", 64'({busy_o, port_req_o}), 64'(0));

        check("exp_addr_drained", 64'(exp_addr_q.size()), 64'(0));
        check("exp_data_drained", 64'(exp_dat_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
